clip_recorder_core: RTL and testbench
=====================================

# clip_recorder_core

Parametrised multi-clip record/playback engine for the audio recorder datapath, generalising the current fixed two-memory/controller arrangement. It sits between the PDM deserializer (sample-valid strobe) and the serializer (sample-request strobe). It owns an inferred single-port RAM partitioned into NUM_CLIPS equal clips and tracks each clip's recorded length. It supports record, one-shot playback, looped playback and stop.

## Interface
- DATA_W, 16, sample width in bits
- NUM_CLIPS, 4, number of clip slots (>=2)
- CLIP_DEPTH, 65536, samples per clip (power of two)
- ADDR_W, $clog2(CLIP_DEPTH), derived offset width
- SEL_W, $clog2(NUM_CLIPS), derived clip-select width

- clock_i  in  1  system clock
- reset_n_i  in  1  one clock; reset is asynchronous and active-low
- rec_start_i  in  1  single-cycle pulse, start recording rec_clip_i
- play_start_i  in  1  single-cycle pulse, start playing play_clip_i
- stop_i  in  1  single-cycle pulse, abort current operation
- loop_i  in  1  level, loop playback at end of clip
- rec_clip_i  in  SEL_W  clip to record
- play_clip_i  in  SEL_W  clip to play
- in_valid_i  in  1  deserializer sample strobe
- in_data_i  in  DATA_W  deserializer sample
- out_ready_i  in  1  serializer next-sample request
- out_valid_o  out  1  one-cycle pulse, out_data_o updated
- out_data_o  out  DATA_W  playback sample, held between pulses
- state_o  out  2  0=IDLE, 1=REC, 2=PLAY
- active_clip_o  out  SEL_W  latched clip of current/last operation
- len_o  out  ADDR_W+1  length of play_clip_i in IDLE, of active clip otherwise
- done_o  out  1  one-cycle pulse on natural completion

## Operation
- RAM: NUM_CLIPS*CLIP_DEPTH words, address {clip, offset}, synchronous read. Contents are not cleared by reset.
- len[k]: ADDR_W+1 bits per clip, reset 0. A clip with len 0 is empty.
- IDLE:
  - rec_start_i -> REC. Latch clip=rec_clip_i, wr_ptr=0, len[clip]=0.
  - play_start_i with len[play_clip_i]!=0 -> PLAY. Latch clip, rd_ptr=0.
  - play_start_i on an empty clip is ignored.
  - rec_start_i and play_start_i in the same cycle: record wins.
  - in_valid_i and out_ready_i are ignored.
- REC:
  - Each in_valid_i writes in_data_i to {clip, wr_ptr}, then wr_ptr++ and len[clip]=wr_ptr+1.
  - The write at wr_ptr=CLIP_DEPTH-1 fills the clip: -> IDLE and done_o.
  - stop_i -> IDLE with no done_o. If in_valid_i arrives in the same cycle, the sample is written first.
  - rec_start_i and play_start_i are ignored.
- PLAY:
  - Each out_ready_i reads {clip, rd_ptr}, then rd_ptr++.
  - After the read at rd_ptr=len-1:
    - loop_i=1 (sampled that cycle): rd_ptr=0, stay in PLAY.
    - loop_i=0: -> IDLE and done_o.
  - stop_i -> IDLE with no done_o. stop_i has priority over a coincident out_ready_i, which is not accepted.
  - Start pulses and in_valid_i are ignored.
- out_valid_o pulses exactly once per accepted read, including the final read that ends PLAY.
- active_clip_o holds its value after returning to IDLE.
- Async reset mid-operation: state IDLE, all pointers and lengths 0, outputs at reset values.

## Timing
- Reset values: out_valid_o=0, out_data_o=0, state_o=0, active_clip_o=0, done_o=0. len_o=0 because all lengths are 0.
- A start or stop pulse at edge N changes state_o at N+1.
- Write latency: a sample is committed at the edge that samples in_valid_i. len_o shows the new length the next cycle.
- Read latency: out_ready_i sampled at edge N gives out_data_o/out_valid_o at N+1. Back-to-back requests every cycle are sustained.
- done_o is asserted in the cycle state_o first reads 0 after natural completion. On playback end it coincides with the final out_valid_o.
- len_o is a combinational mux of registered lengths.

## Test plan
- Reset then play_start_i on clip 0 -> state_o stays 0, no out_valid_o, len_o=0.
- With CLIP_DEPTH=8, record clip 2 with samples 0x1000..0x1004, then stop_i -> len_o=5, no done_o. Then play clip 2 with 5 out_ready_i -> out_data_o 0x1000..0x1004. done_o and state_o=0 arrive with the fifth out_valid_o.
- Record clip 1 with 8 samples -> done_o on the 8th write, state_o=0, len=8. A 9th in_valid_i is ignored and clip 0 is unchanged.
- Play the 5-sample clip with loop_i=1 for 12 requests -> data sequence wraps 0..4,0..4,0,1. No done_o. A later stop_i returns to IDLE without done_o.
- stop_i coincident with in_valid_i in REC -> sample written, len incremented. stop_i coincident with out_ready_i in PLAY -> no out_valid_o.
- Assert reset_n_i low mid-REC -> outputs go to reset values immediately. All len return 0 and play_start_i is then ignored.

Source files
------------

// File: rtl/clip_recorder_core.sv
// Multi-clip record/playback engine: one single-port RAM split into NUM_CLIPS
// equal clips, with a recorded length per clip and record / one-shot / looped play.
module clip_recorder_core #(
  parameter int DATA_W     = 16,
  parameter int NUM_CLIPS  = 4,
  parameter int CLIP_DEPTH = 65536,
  parameter int ADDR_W     = $clog2(CLIP_DEPTH),
  parameter int SEL_W      = $clog2(NUM_CLIPS)
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              rec_start_i,
  input  logic              play_start_i,
  input  logic              stop_i,
  input  logic              loop_i,
  input  logic [SEL_W-1:0]  rec_clip_i,
  input  logic [SEL_W-1:0]  play_clip_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        state_o,
  output logic [SEL_W-1:0]  active_clip_o,
  output logic [ADDR_W:0]   len_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    PLAY = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [SEL_W-1:0]    clip;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W:0]     len [NUM_CLIPS];
  logic [ADDR_W:0]     ptr_inc;
  logic                last_read;
  logic                start_rec;
  logic                start_play;
  logic                wr_en;
  logic                rd_en;
  logic                done_next;
  logic [SEL_W+ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0]   mem [NUM_CLIPS*CLIP_DEPTH];
  logic [DATA_W-1:0]   rd_data;
  logic                rd_seen;
  logic                out_valid;
  logic                done;

  // One pointer serves as wr_ptr in REC and rd_ptr in PLAY; the two never coexist.
  assign ptr_inc   = {1'b0, ptr} + 1'b1;
  assign last_read = (ptr_inc == len[clip]);
  assign ram_addr  = {clip, ptr};

  // NOTE: non-blocking assignments for every clocked register so all state
  // updates at an edge see the same pre-edge values.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_next;
  end

  // NOTE: state_next gets its default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (rec_start_i)                                     state_next = REC;
        else if (play_start_i && (len[play_clip_i] != '0))   state_next = PLAY;
      end
      REC: begin
        if (stop_i || (in_valid_i && (ptr == '1)))           state_next = IDLE;
      end
      PLAY: begin
        if (stop_i)                                          state_next = IDLE;
        else if (out_ready_i && last_read && !loop_i)        state_next = IDLE;
      end
      default:                                               state_next = IDLE;
    endcase
  end

  always_comb begin
    start_rec  = (state == IDLE) && rec_start_i;
    start_play = (state == IDLE) && !rec_start_i && play_start_i &&
                 (len[play_clip_i] != '0);
    wr_en      = (state == REC) && in_valid_i;
    // A stop wins over a coincident request, which is then never accepted.
    rd_en      = (state == PLAY) && out_ready_i && !stop_i;
    done_next  = (wr_en && (ptr == '1)) || (rd_en && last_read && !loop_i);
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      clip      <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      rd_seen   <= 1'b0;
      for (int k = 0; k < NUM_CLIPS; k++) len[k] <= '0;
    end else begin
      out_valid <= rd_en;
      done      <= done_next;
      if (rd_en) rd_seen <= 1'b1;
      if (start_rec) begin
        clip            <= rec_clip_i;
        ptr             <= '0;
        len[rec_clip_i] <= '0;
      end else if (start_play) begin
        clip <= play_clip_i;
        ptr  <= '0;
      end else if (wr_en) begin
        ptr       <= ptr + 1'b1;
        len[clip] <= ptr_inc;
      end else if (rd_en) begin
        ptr <= last_read ? '0 : ptr + 1'b1;
      end
    end
  end

  // NOTE: the sample RAM has no reset so it maps onto block RAM; clearing the
  // lengths is what makes every clip read as empty after reset.
  always_ff @(posedge clock_i) begin
    if (wr_en) mem[ram_addr] <= in_data_i;
    if (rd_en) rd_data       <= mem[ram_addr];
  end

  // rd_data itself is unreset, so the output reads 0 until the first accepted read.
  assign out_data_o    = rd_seen ? rd_data : '0;
  assign out_valid_o   = out_valid;
  assign done_o        = done;
  assign state_o       = state;
  assign active_clip_o = clip;
  assign len_o         = (state == IDLE) ? len[play_clip_i] : len[clip];

endmodule

// File: tb/tb_clip_recorder_core.sv
// Directed, table-driven bench for clip_recorder_core with 4 clips of 8 samples.
module tb_clip_recorder_core;

  localparam int DATA_W     = 16;
  localparam int NUM_CLIPS  = 4;
  localparam int CLIP_DEPTH = 8;
  localparam int ADDR_W     = 3;
  localparam int SEL_W      = 2;

  logic              clock_i = 1'b0;
  logic              reset_n_i;
  logic              rec_start_i, play_start_i, stop_i, loop_i;
  logic [SEL_W-1:0]  rec_clip_i, play_clip_i;
  logic              in_valid_i;
  logic [DATA_W-1:0] in_data_i;
  logic              out_ready_i;
  logic              out_valid_o;
  logic [DATA_W-1:0] out_data_o;
  logic [1:0]        state_o;
  logic [SEL_W-1:0]  active_clip_o;
  logic [ADDR_W:0]   len_o;
  logic              done_o;

  int checks   = 0;
  int failures = 0;

  clip_recorder_core #(
    .DATA_W(DATA_W), .NUM_CLIPS(NUM_CLIPS), .CLIP_DEPTH(CLIP_DEPTH)
  ) dut (
    .clock_i(clock_i), .reset_n_i(reset_n_i),
    .rec_start_i(rec_start_i), .play_start_i(play_start_i),
    .stop_i(stop_i), .loop_i(loop_i),
    .rec_clip_i(rec_clip_i), .play_clip_i(play_clip_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i),
    .out_ready_i(out_ready_i), .out_valid_o(out_valid_o),
    .out_data_o(out_data_o), .state_o(state_o),
    .active_clip_o(active_clip_o), .len_o(len_o), .done_o(done_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    string       tag;
    logic        rs, ps, st, lp;
    logic [1:0]  rc, pc;
    logic        iv;
    logic [15:0] id;
    logic        ordy;
    logic [1:0]  es;
    logic        eov;
    logic [15:0] eod;
    logic        edn;
    logic [3:0]  elen;
    logic [1:0]  eac;
  } vec_t;

  function automatic vec_t v(
    input string tag,
    input logic rs, input logic ps, input logic st, input logic lp,
    input logic [1:0] rc, input logic [1:0] pc,
    input logic iv, input logic [15:0] id, input logic ordy,
    input logic [1:0] es, input logic eov, input logic [15:0] eod,
    input logic edn, input logic [3:0] elen, input logic [1:0] eac);
    vec_t r;
    r.tag = tag; r.rs = rs; r.ps = ps; r.st = st; r.lp = lp;
    r.rc = rc; r.pc = pc; r.iv = iv; r.id = id; r.ordy = ordy;
    r.es = es; r.eov = eov; r.eod = eod; r.edn = edn; r.elen = elen; r.eac = eac;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] es, input logic eov,
                               input logic [15:0] eod, input logic edn,
                               input logic [3:0] elen, input logic [1:0] eac);
    check({tag, ".state"}, 32'(state_o), 32'(es));
    check({tag, ".valid"}, 32'(out_valid_o), 32'(eov));
    check({tag, ".data"},  32'(out_data_o), 32'(eod));
    check({tag, ".done"},  32'(done_o), 32'(edn));
    check({tag, ".len"},   32'(len_o), 32'(elen));
    check({tag, ".clip"},  32'(active_clip_o), 32'(eac));
  endtask

  // Inputs are held across the edge; outputs are sampled 1 ns after it.
  task automatic apply(input vec_t x);
    rec_start_i  = x.rs; play_start_i = x.ps; stop_i = x.st; loop_i = x.lp;
    rec_clip_i   = x.rc; play_clip_i  = x.pc;
    in_valid_i   = x.iv; in_data_i    = x.id; out_ready_i = x.ordy;
    @(posedge clock_i);
    #1;
    check_outputs(x.tag, x.es, x.eov, x.eod, x.edn, x.elen, x.eac);
  endtask

  vec_t tab[$];

  initial begin
    // Record clip 2 with five samples, stop, then one-shot play it back.
    tab.push_back(v("a_play_empty", 0,1,0,0, 0,0, 0,16'h0000,0, 0,0,16'h0000,0,0,0));
    tab.push_back(v("a_rec_start",  1,0,0,0, 2,2, 0,16'h0000,0, 1,0,16'h0000,0,0,2));
    tab.push_back(v("a_wr0",        0,0,0,0, 2,2, 1,16'h1000,0, 1,0,16'h0000,0,1,2));
    tab.push_back(v("a_wr_gap",     0,0,0,0, 2,2, 0,16'h0000,0, 1,0,16'h0000,0,1,2));
    tab.push_back(v("a_wr1",        0,0,0,0, 2,2, 1,16'h1001,0, 1,0,16'h0000,0,2,2));
    tab.push_back(v("a_wr2",        0,0,0,0, 2,2, 1,16'h1002,0, 1,0,16'h0000,0,3,2));
    tab.push_back(v("a_wr3",        0,0,0,0, 2,2, 1,16'h1003,0, 1,0,16'h0000,0,4,2));
    tab.push_back(v("a_wr4",        0,0,0,0, 2,2, 1,16'h1004,0, 1,0,16'h0000,0,5,2));
    tab.push_back(v("a_stop",       0,0,1,0, 2,2, 0,16'h0000,0, 0,0,16'h0000,0,5,2));
    tab.push_back(v("a_play",       0,1,0,0, 2,2, 0,16'h0000,0, 2,0,16'h0000,0,5,2));
    tab.push_back(v("a_rd0",        0,0,0,0, 2,2, 0,16'h0000,1, 2,1,16'h1000,0,5,2));
    tab.push_back(v("a_rd1",        0,0,0,0, 2,2, 0,16'h0000,1, 2,1,16'h1001,0,5,2));
    tab.push_back(v("a_rd_gap",     0,0,0,0, 2,2, 0,16'h0000,0, 2,0,16'h1001,0,5,2));
    tab.push_back(v("a_rd2",        0,0,0,0, 2,2, 0,16'h0000,1, 2,1,16'h1002,0,5,2));
    tab.push_back(v("a_rd3",        0,0,0,0, 2,2, 0,16'h0000,1, 2,1,16'h1003,0,5,2));
    tab.push_back(v("a_rd4_last",   0,0,0,0, 2,2, 0,16'h0000,1, 0,1,16'h1004,1,5,2));
    tab.push_back(v("a_after",      0,0,0,0, 2,2, 0,16'h0000,0, 0,0,16'h1004,0,5,2));

    reset_n_i = 1'b0;
    rec_start_i = 0; play_start_i = 0; stop_i = 0; loop_i = 0;
    rec_clip_i = 0; play_clip_i = 0; in_valid_i = 0; in_data_i = 0; out_ready_i = 0;
    repeat (2) @(posedge clock_i);
    #1;
    check_outputs("reset", 2'd0, 1'b0, 16'h0000, 1'b0, 4'd0, 2'd0);
    @(negedge clock_i);
    reset_n_i = 1'b1;

    foreach (tab[i]) apply(tab[i]);

    // Fill clip 1 completely; record start beats a coincident play start.
    apply(v("b_rec_wins", 1,1,0,0, 1,2, 0,16'h0000,0, 1,0,16'h1004,0,0,1));
    for (int i = 0; i < 8; i++)
      apply(v($sformatf("b_wr%0d", i), 0,0,0,0, 1,1, 1,16'h2000 + 16'(i),0,
              (i == 7) ? 2'd0 : 2'd1, 0,16'h1004, (i == 7), 4'(i + 1), 1));
    apply(v("b_ninth",     0,0,0,0, 1,1, 1,16'hdead,0, 0,0,16'h1004,0,8,1));
    apply(v("b_clip0_len", 0,0,0,0, 1,0, 0,16'h0000,0, 0,0,16'h1004,0,0,1));
    apply(v("b_play",      0,1,0,0, 1,1, 0,16'h0000,0, 2,0,16'h1004,0,8,1));
    for (int i = 0; i < 8; i++)
      apply(v($sformatf("b_rd%0d", i), 0,0,0,0, 1,1, 0,16'h0000,1,
              (i == 7) ? 2'd0 : 2'd2, 1,16'h2000 + 16'(i), (i == 7), 8, 1));

    // Looped playback of clip 2 wraps without a done pulse; stop ends it.
    apply(v("c_play_loop", 0,1,0,1, 0,2, 0,16'h0000,0, 2,0,16'h2007,0,5,2));
    for (int i = 0; i < 12; i++)
      apply(v($sformatf("c_rd%0d", i), 0,0,0,1, 0,2, 0,16'h0000,1,
              2, 1,16'h1000 + 16'(i % 5), 0, 5, 2));
    apply(v("c_stop",      0,0,1,1, 0,2, 0,16'h0000,0, 0,0,16'h1001,0,5,2));

    // Stop coincident with a write keeps the sample; with a read it drops the read.
    apply(v("d_rec",       1,0,0,0, 3,3, 0,16'h0000,0, 1,0,16'h1001,0,0,3));
    apply(v("d_wr0",       0,0,0,0, 3,3, 1,16'h3000,0, 1,0,16'h1001,0,1,3));
    apply(v("d_stop_wr",   0,0,1,0, 3,3, 1,16'h3001,0, 0,0,16'h1001,0,2,3));
    apply(v("d_play",      0,1,0,0, 3,3, 0,16'h0000,0, 2,0,16'h1001,0,2,3));
    apply(v("d_rd0",       0,0,0,0, 3,3, 0,16'h0000,1, 2,1,16'h3000,0,2,3));
    apply(v("d_stop_rd",   0,0,1,0, 3,3, 0,16'h0000,1, 0,0,16'h3000,0,2,3));
    apply(v("d_replay",    0,1,0,0, 3,3, 0,16'h0000,0, 2,0,16'h3000,0,2,3));
    apply(v("d_rr0",       0,0,0,0, 3,3, 0,16'h0000,1, 2,1,16'h3000,0,2,3));
    apply(v("d_rr1",       0,0,0,0, 3,3, 0,16'h0000,1, 0,1,16'h3001,1,2,3));

    // Asynchronous reset in the middle of a recording.
    apply(v("e_rec",       1,0,0,0, 0,0, 0,16'h0000,0, 1,0,16'h3001,0,0,0));
    apply(v("e_wr0",       0,0,0,0, 0,0, 1,16'h4000,0, 1,0,16'h3001,0,1,0));
    in_valid_i = 1'b1;
    in_data_i  = 16'h4001;
    #2;
    reset_n_i = 1'b0;
    #1;
    check_outputs("e_async_rst", 2'd0, 1'b0, 16'h0000, 1'b0, 4'd0, 2'd0);
    in_valid_i = 1'b0;
    @(negedge clock_i);
    @(negedge clock_i);
    reset_n_i = 1'b1;
    for (int k = 0; k < NUM_CLIPS; k++) begin
      play_clip_i = 2'(k);
      #1;
      check($sformatf("e_len_clip%0d", k), 32'(len_o), 32'd0);
    end
    apply(v("e_play_ignored", 0,1,0,0, 0,2, 0,16'h0000,0, 0,0,16'h0000,0,0,0));
    apply(v("e_idle_after",   0,0,0,0, 0,2, 0,16'h0000,1, 0,0,16'h0000,0,0,0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
